// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: instruction width, the NOP encoding and the
// boot loader state enum.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_HI,
        S_LO,
        S_CHK,
        S_RUN,
        S_ERR
    } ld_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Boot byte-stream port: load request pulse plus a valid/ready byte channel.
interface imem_loader_if;

    logic       load_req;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;

    modport master (output load_req, ld_valid, ld_data, input ld_ready);
    modport slave  (input load_req, ld_valid, ld_data, output ld_ready);

endinterface

// File: rtl/imem_ram.sv
// Instruction RAM: synchronous write, asynchronous read, contents never cleared.
module imem_ram
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header byte N, then N big-endian 16-bit words into imem_ram;
// releases the CPU once loaded. `define CHECKSUM_EN adds a trailing XOR byte.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    imem_loader_if.slave       ld,
    input  logic [ADDR_W-1:0]  PC,
    output logic [INSTR_W-1:0] IR,
    output logic               cpu_reset,
    output logic               busy,
    output logic               err,
    output logic [ADDR_W:0]    word_count
);

    localparam int DEPTH = 2**ADDR_W;

    ld_state_e          state;
    logic [ADDR_W-1:0]  addr;
    logic [ADDR_W:0]    n_words;
    logic [7:0]         hi_byte;
    logic [ADDR_W:0]    hdr_n;
    logic               last_word;
    logic               we;
    logic [INSTR_W-1:0] rdata;

`ifdef CHECKSUM_EN
    logic [7:0] xsum;
    logic       err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy        = (state == S_HDR) || (state == S_HI) || (state == S_LO) || (state == S_CHK);
    assign ld.ld_ready = busy && !ld.load_req;
    // Header 0 encodes a full-depth program.
    assign hdr_n       = (ld.ld_data == 8'd0) ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(ld.ld_data);
    assign last_word   = ({1'b0, addr} == n_words - 1'b1);
    assign we          = (state == S_LO) && ld.ld_valid && ld.ld_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cpu_reset  <= 1'b1;
            word_count <= '0;
            n_words    <= '0;
            addr       <= '0;
            hi_byte    <= '0;
`ifdef CHECKSUM_EN
            xsum       <= '0;
            err_q      <= 1'b0;
`endif
        end else if (ld.load_req) begin
            // Restart from any state; a byte offered this cycle is dropped.
            state      <= S_HDR;
            cpu_reset  <= 1'b1;
            word_count <= '0;
`ifdef CHECKSUM_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                S_HDR: if (ld.ld_valid) begin
                    n_words <= hdr_n;
                    addr    <= '0;
`ifdef CHECKSUM_EN
                    xsum    <= '0;
`endif
                    state   <= S_HI;
                end
                S_HI: if (ld.ld_valid) begin
                    hi_byte <= ld.ld_data;
`ifdef CHECKSUM_EN
                    xsum    <= xsum ^ ld.ld_data;
`endif
                    state   <= S_LO;
                end
                S_LO: if (ld.ld_valid) begin
                    addr <= addr + 1'b1;
`ifdef CHECKSUM_EN
                    xsum <= xsum ^ ld.ld_data;
                    state <= last_word ? S_CHK : S_HI;
`else
                    if (last_word) begin
                        state      <= S_RUN;
                        word_count <= n_words;
                    end else begin
                        state      <= S_HI;
                    end
`endif
                end
`ifdef CHECKSUM_EN
                S_CHK: if (ld.ld_valid) begin
                    if (ld.ld_data == xsum) begin
                        state      <= S_RUN;
                        word_count <= n_words;
                    end else begin
                        state      <= S_ERR;
                        err_q      <= 1'b1;
                        word_count <= '0;
                    end
                end
`endif
                S_RUN: cpu_reset <= 1'b0;
                default: ;
            endcase
        end
    end

    imem_ram #(.ADDR_W(ADDR_W), .DATA_W(INSTR_W)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (addr),
        .wdata ({hi_byte, ld.ld_data}),
        .raddr (PC),
        .rdata (rdata)
    );

    // Reads past the loaded program return NOP so the CPU never sees stale words.
    assign IR = ((state == S_RUN) && ({1'b0, PC} < word_count)) ? rdata : NOP_INSTR;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte-stream program model plus per-cycle compare.
module tb_imem_loader;
    import cpu_pkg::*;

    localparam int ADDR_W = 8;
`ifdef CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    typedef enum {P_IDLE, P_LOAD, P_RUN, P_ERR} phase_e;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] PC    = '0;
    logic [15:0]       IR;
    logic              cpu_reset, busy, err;
    logic [ADDR_W:0]   word_count;

    imem_loader_if bus();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .ld         (bus),
        .PC         (PC),
        .IR         (IR),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, need %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: collect accepted bytes; when a whole program is in, publish it.
    phase_e      m_phase = P_IDLE;
    logic [7:0]  m_buf [0:1023];
    int          m_cnt   = 0;
    int          m_wc    = 0;
    bit          m_crst  = 1'b1;
    bit          m_err   = 1'b0;
    logic [15:0] m_mem [256];

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_phase = P_IDLE; m_cnt = 0; m_wc = 0; m_crst = 1'b1; m_err = 1'b0;
        end else if (bus.load_req) begin
            m_phase = P_LOAD; m_cnt = 0; m_wc = 0; m_crst = 1'b1; m_err = 1'b0;
        end else begin
            if (m_phase == P_RUN) m_crst = 1'b0;
            if (m_phase == P_LOAD && bus.ld_valid) begin
                int n;
                logic [7:0] x;
                m_buf[m_cnt] = bus.ld_data;
                m_cnt++;
                n = (m_buf[0] == 8'd0) ? 256 : int'(m_buf[0]);
                if (m_cnt == 1 + 2*n + CS) begin
                    x = 8'd0;
                    for (int i = 1; i <= 2*n; i++) x = x ^ m_buf[i];
                    for (int i = 0; i < n; i++) m_mem[i] = {m_buf[1+2*i], m_buf[2+2*i]};
                    if (CS == 1 && x != m_buf[2*n+1]) begin
                        m_phase = P_ERR; m_err = 1'b1; m_wc = 0;
                    end else begin
                        m_phase = P_RUN; m_wc = n;
                    end
                end
            end
        end
    end

    initial forever begin
        logic [15:0] exp_ir;
        @(negedge clk);
        exp_ir = (m_phase == P_RUN && int'(PC) < m_wc) ? m_mem[PC] : NOP_INSTR;
        chk("cpu_reset", 32'(cpu_reset), 32'(m_crst));
        chk("busy", 32'(busy), 32'(m_phase == P_LOAD));
        chk("ld_ready", 32'(bus.ld_ready), 32'(m_phase == P_LOAD && !bus.load_req));
        chk("err", 32'(err), 32'(m_err));
        chk("word_count", 32'(word_count), 32'(m_wc));
        chk("IR", 32'(IR), 32'(exp_ir));
    end

    // All driving tasks start and end at posedge+1.
    task automatic pulse_load(input bit with_byte, input logic [7:0] b);
        bus.load_req = 1'b1;
        bus.ld_valid = with_byte;
        bus.ld_data  = b;
        @(posedge clk); #1;
        bus.load_req = 1'b0;
        bus.ld_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit r = 1'b0;
        int t = 0;
        bus.ld_valid = 1'b1;
        bus.ld_data  = b;
        while (!r && t < 50) begin
            @(negedge clk);
            r = bus.ld_ready;
            @(posedge clk); #1;
            t++;
        end
        if (!r) begin
            n_chk++;
            $display("FAIL accept_timeout: byte %0h not taken, need accept within 50 cycles", b);
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic send_prog(input logic [7:0] q[$], input int gap, input bit with_cs);
        logic [7:0] x = 8'd0;
        for (int i = 1; i < q.size(); i++) x = x ^ q[i];
        if (CS == 1 && with_cs) q.push_back(x);
        foreach (q[i]) begin
            send_byte(q[i]);
            if (gap > 0 && i != q.size() - 1) repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic ir_at(input logic [7:0] pc, input logic [15:0] exp, input string name);
        PC = pc;
        @(negedge clk);
        chk(name, 32'(IR), 32'(exp));
        @(posedge clk); #1;
    endtask

    task automatic release_check(input string name);
        @(negedge clk);
        chk({name, "_hold"}, 32'(cpu_reset), 32'd1);
        @(negedge clk);
        chk({name, "_fall"}, 32'(cpu_reset), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, need completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        bus.load_req = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'h00;

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_wc", 32'(word_count), 32'd0);
        chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("idle_ir", 32'(IR), 32'h0);
        @(posedge clk); #1;

        // two words back-to-back
        pulse_load(1'b0, 8'h00);
        q = '{8'h02, 8'h98, 8'h03, 8'h04, 8'h41};
        send_prog(q, 0, 1'b1);
        release_check("two");
        chk("two_wc", 32'(word_count), 32'd2);
        ir_at(8'h00, 16'h9803, "two_ir0");
        ir_at(8'h01, 16'h0441, "two_ir1");
        ir_at(8'h05, 16'h0000, "two_ir5");

        // same stream with ld_valid gaps
        pulse_load(1'b0, 8'h00);
        send_prog(q, 1, 1'b1);
        release_check("gap");
        ir_at(8'h00, 16'h9803, "gap_ir0");
        ir_at(8'h01, 16'h0441, "gap_ir1");

        // restart after the third byte; the byte with load_req is dropped
        pulse_load(1'b0, 8'h00);
        send_byte(8'h02); send_byte(8'h98); send_byte(8'h03);
        pulse_load(1'b1, 8'h04);
        q = '{8'h01, 8'h12, 8'h34};
        send_prog(q, 0, 1'b1);
        release_check("rst");
        chk("rst_wc", 32'(word_count), 32'd1);
        ir_at(8'h00, 16'h1234, "rst_ir0");
        ir_at(8'h01, 16'h0000, "rst_ir1");

        // full depth: header 00, word i = {i, ~i}
        pulse_load(1'b0, 8'h00);
        q = '{8'h00};
        for (int i = 0; i < 256; i++) begin
            q.push_back(8'(i));
            q.push_back(~8'(i));
        end
        send_prog(q, 0, 1'b1);
        release_check("full");
        chk("full_wc", 32'(word_count), 32'd256);
        ir_at(8'hFF, 16'hFF00, "full_irFF");
        ir_at(8'h00, 16'h00FF, "full_ir00");
        ir_at(8'h80, 16'h807F, "full_ir80");

`ifdef CHECKSUM_EN
        // bad checksum then recovery
        pulse_load(1'b0, 8'h00);
        q = '{8'h01, 8'h12, 8'h34, 8'h00};
        send_prog(q, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("bad_wc", 32'(word_count), 32'd0);
        @(posedge clk); #1;
        ir_at(8'h00, 16'h0000, "bad_ir0");
        pulse_load(1'b0, 8'h00);
        q = '{8'h01, 8'h12, 8'h34, 8'h26};
        send_prog(q, 0, 1'b0);
        release_check("good");
        chk("good_err", 32'(err), 32'd0);
        ir_at(8'h00, 16'h1234, "good_ir0");
`endif

        // asynchronous reset in the middle of a load
        pulse_load(1'b0, 8'h00);
        send_byte(8'h01); send_byte(8'h12);
        #2 reset = 1'b0;
        #1;
        chk("areset_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("areset_busy", 32'(busy), 32'd0);
        chk("areset_wc", 32'(word_count), 32'd0);
        chk("areset_ready", 32'(bus.ld_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_cpu_reset", 32'(cpu_reset), 32'd1);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
